// File: rtl/fpmul_pkg.sv
// Shared constants, types and operand classification for the binary32 multiplier.
package fpmul_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_NORM,
        ST_RND,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
        logic             is_snan;
    } fp_unpacked_t;

    // Exponent field 0 is treated as zero (subnormals flushed on input).
    function automatic fp_unpacked_t unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.man     = x[22:0];
        u.is_zero = (u.exp == 8'h00);
        u.is_inf  = (u.exp == 8'hFF) && (u.man == '0);
        u.is_nan  = (u.exp == 8'hFF) && (u.man != '0);
        u.is_snan = u.is_nan && !u.man[MAN_W-1];
        return u;
    endfunction

endpackage

// File: rtl/booth.sv
// Radix-2 Booth sequential multiplier: signed N x N, one recoding step per cycle.
module booth #(
    parameter int N = 25
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           mult_term,
    input  logic [N-1:0]   mc,
    input  logic [N-1:0]   mp,
    output logic [2*N-1:0] product,
    output logic           mult_done
);

    localparam int CNT_W = $clog2(N + 1);

    logic [N:0]       acc_q, acc_d;
    logic [N-1:0]     q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [N-1:0]     mc_q, mc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [N:0]       sum;

    // Next-state: load on start, one add/sub + arithmetic shift per cycle, done at terminal count.
    always_comb begin
        acc_d  = acc_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        mc_d   = mc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        sum    = acc_q;
        if (start) begin
            acc_d  = '0;
            q_d    = mp;
            qm1_d  = 1'b0;
            mc_d   = mc;
            cnt_d  = CNT_W'(N);
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (mult_term) begin
            run_d  = 1'b0;
            done_d = 1'b0;
        end else if (run_q) begin
            case ({q_q[0], qm1_q})
                2'b01:   sum = acc_q + {mc_q[N-1], mc_q};
                2'b10:   sum = acc_q - {mc_q[N-1], mc_q};
                default: sum = acc_q;
            endcase
            acc_d = {sum[N], sum[N:1]};
            q_d   = {sum[0], q_q[N-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            mc_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            mc_q   <= mc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign product   = {acc_q[N-1:0], q_q};
    assign mult_done = done_q;

endmodule

// File: rtl/fpmul_round.sv
// Round-to-nearest-even, range check and packing of a normalized product.
module fpmul_round
    import fpmul_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic signed [9:0] exp_i,
    input  logic             sign_i,
    output logic [31:0]      result_o,
    output logic [3:0]       flags_o
);

    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic signed [9:0] exp_r;

    // Round, propagate the mantissa carry into the exponent, then saturate or flush.
    always_comb begin
        round_up = guard_i & (sticky_i | man_i[0]);
        man_sum  = {1'b0, man_i} + {{MAN_W{1'b0}}, round_up};
        exp_r    = exp_i + {9'b0, man_sum[MAN_W]};
        result_o = '0;
        flags_o  = '0;
        if (exp_r >= 10'sd255) begin
            result_o                = {sign_i, 8'hFF, {MAN_W{1'b0}}};
            flags_o[FLG_OVERFLOW]   = 1'b1;
            flags_o[FLG_INEXACT]    = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result_o                = {sign_i, 31'b0};
            flags_o[FLG_UNDERFLOW]  = 1'b1;
            flags_o[FLG_INEXACT]    = 1'b1;
        end else begin
            result_o                = {sign_i, exp_r[7:0], man_sum[MAN_W-1:0]};
            flags_o[FLG_INEXACT]    = guard_i | sticky_i;
        end
    end

endmodule

// File: rtl/fpmul_seq.sv
// Binary32 multiply sequencer: special-case screen, Booth mantissa multiply,
// normalize, round and hand the result out over valid/ready.
//   state | meaning
//   IDLE  | ready for an operand pair
//   WAIT  | Booth multiplier running
//   NORM  | normalize product, extract guard/sticky
//   RND   | round and pack result/flags
//   OUT   | result presented until out_ready
module fpmul_seq
    import fpmul_pkg::*;
#(
    parameter int FTZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        busy
);

    if (FTZ != 1) begin : g_ftz_check
        $error("fpmul_seq: only FTZ=1 is implemented");
    end

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [MAN_W-1:0]  man_q, man_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              out_valid_q, out_valid_d;

    fp_unpacked_t      ua, ub;
    logic              accept;
    logic              special;
    logic [31:0]       special_res;
    logic [3:0]        special_flg;
    logic              sign_p;

    logic [49:0]       product;
    logic [47:0]       prod;
    logic [1:0]        prod_unused_hi;
    logic              mult_done;
    logic              mult_start;
    logic              mult_term;

    logic [31:0]       rnd_result;
    logic [3:0]        rnd_flags;

    assign ua             = unpack(a);
    assign ub             = unpack(b);
    assign sign_p         = ua.sign ^ ub.sign;
    assign accept         = in_valid && (state_q == ST_IDLE);
    assign prod           = product[47:0];
    assign prod_unused_hi = product[49:48];

    // Special operand screen; results of this path bypass the multiplier entirely.
    always_comb begin
        special     = 1'b1;
        special_res = '0;
        special_flg = '0;
        if (ua.is_nan || ub.is_nan) begin
            special_res              = QNAN;
            special_flg[FLG_INVALID] = ua.is_snan | ub.is_snan;
        end else if ((ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
            special_res              = QNAN;
            special_flg[FLG_INVALID] = 1'b1;
        end else if (ua.is_inf || ub.is_inf) begin
            special_res = {sign_p, 8'hFF, {MAN_W{1'b0}}};
        end else if (ua.is_zero || ub.is_zero) begin
            special_res = {sign_p, 31'b0};
        end else begin
            special = 1'b0;
        end
    end

    assign mult_start = accept && !special;
    assign mult_term  = abort && (state_q != ST_IDLE);

    booth #(.N(25)) u_booth (
        .clk       (clk),
        .reset     (reset),
        .start     (mult_start),
        .mult_term (mult_term),
        .mc        ({1'b0, 1'b1, ua.man}),
        .mp        ({1'b0, 1'b1, ub.man}),
        .product   (product),
        .mult_done (mult_done)
    );

    fpmul_round u_round (
        .man_i    (man_q),
        .guard_i  (guard_q),
        .sticky_i (sticky_q),
        .exp_i    (exp_q),
        .sign_i   (sign_q),
        .result_o (rnd_result),
        .flags_o  (rnd_flags)
    );

    // Sequencer next-state and datapath updates; abort outside IDLE overrides everything.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sign_d = sign_p;
                    if (special) begin
                        result_d    = special_res;
                        flags_d     = special_flg;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        exp_d   = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mult_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                // Product of two [1,2) significands lies in [1,4): at most one shift.
                if (prod[47]) begin
                    man_d    = prod[46:24];
                    guard_d  = prod[23];
                    sticky_d = |prod[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    man_d    = prod[45:23];
                    guard_d  = prod[22];
                    sticky_d = |prod[21:0];
                end
                state_d = ST_RND;
            end
            ST_RND: begin
                result_d    = rnd_result;
                flags_d     = rnd_flags;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        if (mult_term) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            man_q       <= man_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fpmul_seq.sv
// Scoreboard bench for fpmul_seq: driver pushes model results, monitor pops on handshake.
module tb_fpmul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    fpmul_seq #(.FTZ(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: IEEE binary32 multiply with FTZ, RNE, using whole-number significand arithmetic.
    function automatic void ref_mul(input logic [31:0] xa, input logic [31:0] xb,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output bit sp);
        int unsigned ea = xa[30:23];
        int unsigned eb = xb[30:23];
        int unsigned fa = xa[22:0];
        int unsigned fb = xb[22:0];
        bit s = xa[31] ^ xb[31];
        bit za = (ea == 0), zb = (eb == 0);
        bit ia = (ea == 255) && (fa == 0), ib = (eb == 255) && (fb == 0);
        bit na = (ea == 255) && (fa != 0), nb = (eb == 255) && (fb != 0);
        bit sna = na && (fa < 32'h400000), snb = nb && (fb < 32'h400000);
        longint unsigned p, kept, rem, half;
        int e, sh;
        r = '0; f = '0; sp = 1;
        if (na || nb) begin
            r = 32'h7FC00000; f = {sna || snb, 3'b000};
        end else if ((ia && zb) || (za && ib)) begin
            r = 32'h7FC00000; f = 4'b1000;
        end else if (ia || ib) begin
            r = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            r = {s, 31'd0};
        end else begin
            sp = 0;
            p = (64'(fa) + 64'd8388608) * (64'(fb) + 64'd8388608);
            e = int'(ea) + int'(eb) - 127;
            if (p >= 64'd140737488355328) begin sh = 24; e = e + 1; end
            else sh = 23;
            kept = p >> sh;
            rem  = p - (kept << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            if (kept == 64'd16777216) begin kept = 64'd8388608; e = e + 1; end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'd0}; f = 4'b0011;
            end else begin
                r = {s, e[7:0], kept[22:0]}; f = {3'b000, rem != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m = 23'($urandom);
        int k = $urandom_range(0, 11);
        case (k)
            0: e = 8'd0;
            1: begin e = 8'hFF; m = '0; end
            2: begin e = 8'hFF; if (m == 0) m = 23'd1; end
            3: e = 8'($urandom_range(1, 20));
            4: e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input bit keep);
        exp_t e;
        bit   sp;
        int   n = 0;
        ref_mul(xa, xb, e.res, e.flg, sp);
        e.lat = sp ? 0 : 28;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        if (!in_ready) return;
        a = xa; b = xb; in_valid = 1'b1;
        e.acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (keep) sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare on handshake, check hold during stalls.
    initial begin
        bit          prev_ov = 0;
        bit          prev_stall = 0;
        logic [31:0] held_res = '0;
        logic [3:0]  held_flg = '0;
        int          rise_cyc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov = 0; prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_result", result, held_res);
                chk("stall_flags", flags, held_flg);
            end
            if (out_valid && !prev_ov) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("flags", flags, e.flg);
                    chk("latency", rise_cyc - e.acc_cyc, e.lat);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_res = result;
            held_flg = flags;
            prev_ov = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", flags, 4'h0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // directed cases from the feature list
        issue(32'h3FC00000, 32'h40000000, 1); drain();
        issue(32'h3F800001, 32'h3F800001, 1); drain();
        issue(32'h7F000000, 32'h7F000000, 1); drain();
        issue(32'h00800000, 32'h00800000, 1); drain();
        issue(32'h00000000, 32'h7F800000, 1); drain();
        issue(32'hFF800000, 32'h40000000, 1); drain();
        issue(32'h7F800001, 32'h3F800000, 1); drain();
        issue(32'h3F7FFFFF, 32'h3F800001, 1); drain();

        // abort coinciding with accept in IDLE: accept wins
        abort = 1'b1;
        issue(32'h40400000, 32'h40400000, 1);
        abort = 1'b0;
        drain();

        // abort in WAIT
        issue(32'h3FC00000, 32'h40000000, 0);
        repeat (9) begin @(posedge clk); #1; end
        chk("abort_busy_before", busy, 1'b1);
        chk("abort_in_ready_before", in_ready, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (40) begin @(posedge clk); #1; end
        issue(32'h40000000, 32'h40400000, 1); drain();

        // output stall
        rdy_mode = 2;
        issue(32'h3F800001, 32'h3F800001, 1);
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("stall_out_valid_seen", out_valid, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        rdy_mode = 0;
        drain();

        // reset mid-WAIT
        issue(32'h40000000, 32'h40400000, 0);
        repeat (12) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_flags", flags, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(32'h3FC00000, 32'h40000000, 1); drain();

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            issue(rand_fp(), rand_fp(), 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();
        rdy_mode = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
